dmem_arbiter: RTL

- Two-port arbiter and sequencer in front of the single-port data memory.
- Port 0 is the CPU load/store stage; port 1 is the DMA/debug loader.
- Grants one requester at a time with round-robin fairness and runs one memory access per grant.
- Rejects out-of-range addresses with an error acknowledge.

---
 rtl/dmem_arbiter_if.sv | 38 +++
 rtl/dmem_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the dmem_arbiter and the single-port data memory.
// The arbiter uses the slave view; requesters and the memory use the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack0;
    logic                  ack1;
    logic                  err0;
    logic                  err1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
        output ack0, ack1, err0, err1, rdata0, rdata1,
               mem_read, mem_write, mem_address, mem_write_data
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
        input  ack0, ack1, err0, err1, rdata0, rdata1,
               mem_read, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of a single-port data memory.
// One access per grant: IDLE (arbitrate) -> ACCESS (memory cycle) -> RESP (ack pulse).
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(MEM_DEPTH);

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  cur_q, cur_d;
    logic                  we_l_q, we_l_d;
    logic                  range_err_q, range_err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic                  gnt_valid;
    logic                  gnt_port;
    logic [ADDR_WIDTH-1:0] gnt_addr;

    // On a tie the port that was not served last wins.
    always_comb begin
        gnt_valid = bus.req0 | bus.req1;
        gnt_port  = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
        gnt_addr  = gnt_port ? bus.addr1 : bus.addr0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cur_q        <= 1'b0;
            we_l_q       <= 1'b0;
            range_err_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_q        <= cur_d;
            we_l_q       <= we_l_d;
            range_err_q  <= range_err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // NOTE: every signal gets a hold default before the case so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_d        = cur_q;
        we_l_d       = we_l_q;
        range_err_d  = range_err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d      = ACCESS;
                    cur_d        = gnt_port;
                    last_grant_d = gnt_port;
                    addr_d       = gnt_addr;
                    wdata_d      = gnt_port ? bus.wdata1 : bus.wdata0;
                    we_l_d       = gnt_port ? bus.we1 : bus.we0;
                    range_err_d  = (gnt_addr >= DEPTH_W);
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!range_err_q && !we_l_q) begin
                    if (cur_q) rdata1_d = bus.mem_read_data;
                    else       rdata0_d = bus.mem_read_data;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from registered state only; no path from req/addr inputs.
    always_comb begin
        bus.mem_read       = (state_q == ACCESS) && !range_err_q && !we_l_q;
        bus.mem_write      = (state_q == ACCESS) && !range_err_q &&  we_l_q;
        bus.mem_address    = addr_q;
        bus.mem_write_data = wdata_q;
        bus.ack0           = (state_q == RESP) && !cur_q;
        bus.ack1           = (state_q == RESP) &&  cur_q;
        bus.err0           = (state_q == RESP) && !cur_q && range_err_q;
        bus.err1           = (state_q == RESP) &&  cur_q && range_err_q;
        bus.rdata0         = rdata0_q;
        bus.rdata1         = rdata1_q;
    end
endmodule
